// File: rtl/rgb_lut_sequencer_if.sv
// rtl/rgb_lut_sequencer_if.sv - pixel in, shared LUT port and result out bundle
interface rgb_lut_sequencer_if #(
  parameter int DW = 8,
  parameter int OW = 18
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] R;
  logic [DW-1:0] G;
  logic [DW-1:0] B;
  logic          lut_en;
  logic [DW-1:0] lut_in;
  logic [OW-1:0] lut_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] RO;
  logic [DW-1:0] GO;
  logic [DW-1:0] BO;
  logic [OW-1:0] ro;
  logic [OW-1:0] go;
  logic [OW-1:0] bo;
  logic          busy;

  modport master (
    input  in_valid, R, G, B, lut_out, out_ready,
    output in_ready, lut_en, lut_in, out_valid, RO, GO, BO, ro, go, bo, busy
  );

  modport slave (
    output in_valid, R, G, B, lut_out, out_ready,
    input  in_ready, lut_en, lut_in, out_valid, RO, GO, BO, ro, go, bo, busy
  );
endinterface

// File: rtl/rgb_lut_sequencer.sv
// rtl/rgb_lut_sequencer.sv - one divider LUT time-shared across the R, G, B lookups of a pixel
// Define RGB_LUT_ZERO_SKIP_EN to skip the lookup of zero-valued channels.
module rgb_lut_sequencer #(
  parameter int LUT_LAT = 0,
  parameter int DW      = 8,
  parameter int OW      = 18
) (
  input logic                 CLK,
  input logic                 RST,
  rgb_lut_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOOK, DONE} state_t;

  localparam logic [1:0] LAT     = LUT_LAT[1:0];
  localparam logic [1:0] CH_NONE = 2'd3;

  state_t        state, state_nx;
  logic [1:0]    ch, wc, start_ch, next_ch;
  logic          take, last_wait, in_ready, out_valid, lut_en;
  logic [DW-1:0] cap_r, cap_g, cap_b, lut_addr;
  logic [OW-1:0] res_r, res_g, res_b;

  function automatic logic [DW-1:0] pick(input logic [1:0] c, input logic [DW-1:0] r, g, b);
    case (c)
      2'd0:    pick = r;
      2'd1:    pick = g;
      2'd2:    pick = b;
      default: pick = '0;
    endcase
  endfunction

`ifdef RGB_LUT_ZERO_SKIP_EN
  logic [2:0] nz_in;
  logic [1:0] nz_cap;
  assign nz_in  = {|bus.B, |bus.G, |bus.R};
  assign nz_cap = {|cap_b, |cap_g};
  // CH_NONE from either selector means no lookup is left for this pixel
  always_comb begin
    start_ch = nz_in[0] ? 2'd0 : nz_in[1] ? 2'd1 : nz_in[2] ? 2'd2 : CH_NONE;
    next_ch  = (ch == 2'd0 && nz_cap[0]) ? 2'd1 :
               (ch != 2'd2 && nz_cap[1]) ? 2'd2 : CH_NONE;
  end
`else
  assign start_ch = 2'd0;
  assign next_ch  = ch + 2'd1;
`endif

  assign last_wait = (wc == LAT);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    lut_en    = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        take     = bus.in_valid;
      end
      LOOK: begin
        lut_en = 1'b1;
        if (last_wait && next_ch == CH_NONE) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          take     = bus.in_valid;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (take) state_nx = (start_ch == CH_NONE) ? DONE : LOOK;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ch       <= '0;
      wc       <= '0;
      lut_addr <= '0;
      cap_r    <= '0;
      cap_g    <= '0;
      cap_b    <= '0;
      res_r    <= '0;
      res_g    <= '0;
      res_b    <= '0;
    end else if (take) begin
      cap_r    <= bus.R;
      cap_g    <= bus.G;
      cap_b    <= bus.B;
      ch       <= start_ch;
      wc       <= '0;
      lut_addr <= pick(start_ch, bus.R, bus.G, bus.B);
`ifdef RGB_LUT_ZERO_SKIP_EN
      if (!nz_in[0]) res_r <= '0;
      if (!nz_in[1]) res_g <= '0;
      if (!nz_in[2]) res_b <= '0;
`endif
    end else if (state == LOOK) begin
      if (last_wait) begin
        case (ch)
          2'd0:    res_r <= bus.lut_out;
          2'd1:    res_g <= bus.lut_out;
          2'd2:    res_b <= bus.lut_out;
          default: ;
        endcase
        ch       <= next_ch;
        wc       <= '0;
        lut_addr <= pick(next_ch, cap_r, cap_g, cap_b);
      end else begin
        wc <= wc + 2'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.lut_en    = lut_en;
  assign bus.lut_in    = lut_addr;
  assign bus.RO        = cap_r;
  assign bus.GO        = cap_g;
  assign bus.BO        = cap_b;
  assign bus.ro        = res_r;
  assign bus.go        = res_g;
  assign bus.bo        = res_b;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_rgb_lut_sequencer.sv
// tb/tb_rgb_lut_sequencer.sv - directed bench for rgb_lut_sequencer at LUT_LAT 0 and 2
// Honours RGB_LUT_ZERO_SKIP_EN for the zero-channel steps.
module tb_rgb_lut_sequencer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rgb_lut_sequencer_if #(.DW(8), .OW(18)) b0 ();
  rgb_lut_sequencer_if #(.DW(8), .OW(18)) b2 ();

  rgb_lut_sequencer #(.LUT_LAT(0), .DW(8), .OW(18)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
  rgb_lut_sequencer #(.LUT_LAT(2), .DW(8), .OW(18)) dut2 (.CLK(CLK), .RST(RST), .bus(b2));

  // LUT stubs: out = in*257; junk while disabled so a stray capture shows up
  logic [17:0] p1, p2;
  assign b0.lut_out = b0.lut_en ? {2'b00, b0.lut_in, b0.lut_in} : 18'h2A5A5;
  always @(posedge CLK) begin
    p1 <= {2'b00, b2.lut_in, b2.lut_in};
    p2 <= p1;
  end
  assign b2.lut_out = b2.lut_en ? p2 : 18'h2A5A5;

  typedef struct packed {
    logic [7:0]  r, g, b;
    logic [17:0] lr, lg, lb;
  } res_t;

  res_t       sb[$];
  int         cap_cyc[$];
  int         out_cyc[$];
  logic [7:0] lq0[$];
  logic [7:0] lq2[$];
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;
  int         fails = 0;

  function automatic res_t model(input logic [7:0] r, g, b);
    res_t m;
    m.r  = r;
    m.g  = g;
    m.b  = b;
    m.lr = 18'(r) * 18'd257;
    m.lg = 18'(g) * 18'd257;
    m.lb = 18'(b) * 18'd257;
    return m;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept0(input string tag);
    int n = 0;
    while (!b0.in_ready && n < 40) begin
      step();
      n++;
    end
    check(tag, b0.in_ready, 1'b1);
    step();
  endtask

  task automatic measure0(output int lat);
    lat = 0;
    while (!b0.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (b0.in_valid && b0.in_ready) cap_cyc.push_back(cyc);
      if (b0.lut_en) lq0.push_back(b0.lut_in);
      if (b2.lut_en) lq2.push_back(b2.lut_in);
      if (b0.out_valid && b0.out_ready) begin
        out_cyc.push_back(cyc);
        if (sb.size() == 0) check("sb_unexpected_result", sb.size(), 1);
        else check("sb_result", {b0.RO, b0.GO, b0.BO, b0.ro, b0.go, b0.bo}, sb.pop_front());
      end
    end
  end

  initial begin
    int   lat, oc, cc, n;
    bit   ok;
    res_t e;

    b0.in_valid = 0; b0.out_ready = 1; b0.R = 0; b0.G = 0; b0.B = 0;
    b2.in_valid = 0; b2.out_ready = 1; b2.R = 0; b2.G = 0; b2.B = 0;
    RST = 1;
    repeat (3) step();
    RST = 0;

    // reset state
    check("rst_ctrl0", {b0.in_ready, b0.out_valid, b0.lut_en, b0.busy}, 4'b1000);
    check("rst_data0", {b0.lut_in, b0.RO, b0.GO, b0.BO, b0.ro, b0.go, b0.bo}, '0);
    check("rst_ctrl2", {b2.in_ready, b2.out_valid, b2.lut_en, b2.busy}, 4'b1000);

    // single pixel, LUT_LAT=0
    lq0.delete();
    b0.R = 8'd255; b0.G = 8'd128; b0.B = 8'd1; b0.in_valid = 1;
    sb.push_back(model(8'd255, 8'd128, 8'd1));
    accept0("t2_accept");
    b0.in_valid = 0;
    measure0(lat);
    check("t2_latency", lat, 3);
    check("t2_ro", b0.ro, 18'h0FFFF);
    check("t2_go", b0.go, 18'h08080);
    check("t2_bo", b0.bo, 18'h00101);
    check("t2_caps", {b0.RO, b0.GO, b0.BO}, 24'hFF8001);
    check("t2_lut_count", lq0.size(), 3);
    check("t2_lut_seq", {lq0[0], lq0[1], lq0[2]}, 24'hFF8001);
    step();
    check("t2_idle_after", {b0.out_valid, b0.busy, b0.in_ready}, 3'b001);

    // back-to-back with in_valid held
    oc = out_cyc.size();
    cc = cap_cyc.size();
    b0.R = 8'd10; b0.G = 8'd20; b0.B = 8'd30; b0.in_valid = 1;
    sb.push_back(model(8'd10, 8'd20, 8'd30));
    accept0("t3_accept1");
    b0.R = 8'd40; b0.G = 8'd50; b0.B = 8'd60;
    sb.push_back(model(8'd40, 8'd50, 8'd60));
    accept0("t3_accept2");
    b0.in_valid = 0;
    n = 0;
    while (out_cyc.size() < oc + 2 && n < 40) begin
      step();
      n++;
    end
    check("t3_two_results", out_cyc.size() - oc, 2);
    check("t3_spacing", out_cyc[oc+1] - out_cyc[oc], 4);
    check("t3_no_bubble", cap_cyc[cc+1], out_cyc[oc]);

    // backpressure in DONE
    b0.out_ready = 0;
    b0.R = 8'd7; b0.G = 8'd8; b0.B = 8'd9; b0.in_valid = 1;
    e = model(8'd7, 8'd8, 8'd9);
    sb.push_back(e);
    accept0("t4_accept");
    b0.in_valid = 0;
    measure0(lat);
    check("t4_latency", lat, 3);
    b0.R = 8'd99; b0.G = 8'd98; b0.B = 8'd97; b0.in_valid = 1;
    cc = cap_cyc.size();
    ok = 1;
    repeat (5) begin
      step();
      if (!(b0.out_valid === 1'b1 && b0.in_ready === 1'b0 &&
            {b0.RO, b0.GO, b0.BO, b0.ro, b0.go, b0.bo} === e)) ok = 0;
    end
    check("t4_held_stable", ok, 1'b1);
    check("t4_no_capture", cap_cyc.size(), cc);
    b0.in_valid = 0;
    oc = out_cyc.size();
    b0.out_ready = 1;
    repeat (4) step();
    check("t4_one_transfer", out_cyc.size() - oc, 1);

    // LUT_LAT=2 instance
    lq2.delete();
    b2.R = 8'd3; b2.G = 8'd4; b2.B = 8'd5; b2.in_valid = 1;
    check("t5_ready", b2.in_ready, 1'b1);
    step();
    b2.in_valid = 0;
    lat = 0;
    while (!b2.out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("t5_latency", lat, 9);
    check("t5_results", {b2.ro, b2.go, b2.bo}, {18'd771, 18'd1028, 18'd1285});
    check("t5_lut_count", lq2.size(), 9);
    ok = 1;
    for (int i = 0; i < 9; i++)
      if (lq2.size() != 9 || lq2[i] !== 8'(3 + i / 3)) ok = 0;
    check("t5_lut_held", ok, 1'b1);
    step();
    check("t5_released", b2.out_valid, 1'b0);

    // reset during the G lookup
    b0.R = 8'd11; b0.G = 8'd22; b0.B = 8'd33; b0.in_valid = 1;
    accept0("t6_accept");
    b0.in_valid = 0;
    step();
    check("t6_on_g", b0.lut_in, 8'd22);
    oc = out_cyc.size();
    RST = 1;
    step();
    RST = 0;
    check("t6_ctrl", {b0.in_ready, b0.out_valid, b0.lut_en, b0.busy}, 4'b1000);
    check("t6_data", {b0.lut_in, b0.RO, b0.GO, b0.BO, b0.ro, b0.go, b0.bo}, '0);
    repeat (6) step();
    check("t6_no_result", out_cyc.size(), oc);

    // zero channels
    lq0.delete();
    b0.R = 8'd0; b0.G = 8'd0; b0.B = 8'd7; b0.in_valid = 1;
    sb.push_back(model(8'd0, 8'd0, 8'd7));
    accept0("t7_accept");
    b0.in_valid = 0;
    measure0(lat);
    check("t7_bo", b0.bo, 18'd1799);
    check("t7_ro_go", {b0.ro, b0.go}, 36'd0);
`ifdef RGB_LUT_ZERO_SKIP_EN
    check("t7_latency", lat, 1);
    check("t7_lut_count", lq0.size(), 1);
    step();
    lq0.delete();
    b0.R = 8'd0; b0.G = 8'd0; b0.B = 8'd0; b0.in_valid = 1;
    sb.push_back(model(8'd0, 8'd0, 8'd0));
    accept0("t8_accept");
    b0.in_valid = 0;
    measure0(lat);
    check("t8_latency", lat, 0);
    check("t8_lut_count", lq0.size(), 0);
`else
    check("t7_latency", lat, 3);
    check("t7_lut_count", lq0.size(), 3);
`endif
    repeat (3) step();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
